// File: rtl/vc_credit_rr_arbiter.sv
// Round-robin arbiter gated by a downstream credit counter with sticky overflow.
// Define VC_CREDIT_ARB_BYPASS_EN to make a credit returned at zero usable the same cycle.
module vc_credit_rr_arbiter #(
    parameter int NREQS   = 4,
    parameter int CREDITS = 4,
    parameter int CW      = 3,
    parameter int IW      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQS-1:0] req_val,
    output logic [NREQS-1:0] req_rdy,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [IW-1:0]    out_id,
    input  logic             credit_return,
    output logic [CW-1:0]    credit_count,
    output logic             credit_zero,
    output logic             credit_overflow
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] credit_q, credit_d;
    logic          ovf_q, ovf_d;
    logic [IW-1:0] winner;
    logic          found;
    logic          avail;
    logic          fire;
    int            idx;

`ifdef VC_CREDIT_ARB_BYPASS_EN
    assign avail = (credit_q != '0) || credit_return;
`else
    assign avail = (credit_q != '0);
`endif

    // Rotating priority search starting at the pointer.
    always_comb begin
        winner = ptr_q;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NREQS; k++) begin
            idx = (int'(ptr_q) + k) % NREQS;
            if (!found && req_val[idx]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

    // Reset also blanks the combinational grant so nothing leaks while it is held.
    assign out_val = (|req_val) && avail && !reset;
    assign fire    = out_val && out_rdy;
    assign out_id  = winner;

    always_comb begin
        req_rdy = '0;
        if (fire) begin
            req_rdy[winner] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (fire) begin
            if (winner == IW'(NREQS - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = winner + 1'b1;
            end
        end
    end

    always_comb begin
        credit_d = credit_q;
        ovf_d    = ovf_q;
        if (fire && !credit_return) begin
            credit_d = credit_q - 1'b1;
        end else if (credit_return && !fire) begin
            if (credit_q == CW'(CREDITS)) begin
                ovf_d = 1'b1;
            end else begin
                credit_d = credit_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q    <= '0;
            credit_q <= CW'(CREDITS);
            ovf_q    <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            ovf_q    <= ovf_d;
        end
    end

    assign credit_count    = credit_q;
    assign credit_zero     = (credit_q == '0);
    assign credit_overflow = ovf_q;

endmodule

// File: tb/tb_vc_credit_rr_arbiter.sv
// Scoreboard bench for vc_credit_rr_arbiter: driver queues expected outputs,
// a negedge monitor pops and compares them.
module tb_vc_credit_rr_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req_val;
    logic [3:0] req_rdy;
    logic       out_val;
    logic       out_rdy;
    logic [1:0] out_id;
    logic       credit_return;
    logic [2:0] credit_count;
    logic       credit_zero;
    logic       credit_overflow;

    vc_credit_rr_arbiter #(
        .NREQS(4), .CREDITS(4), .CW(3), .IW(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_val(req_val),
        .req_rdy(req_rdy),
        .out_val(out_val),
        .out_rdy(out_rdy),
        .out_id(out_id),
        .credit_return(credit_return),
        .credit_count(credit_count),
        .credit_zero(credit_zero),
        .credit_overflow(credit_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic       v;
        logic [1:0] id;
        logic [3:0] rdy;
        logic [2:0] cnt;
        logic       zero;
        logic       ovf;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic step(input string nm, input logic rs, input logic [3:0] rq,
                        input logic rd, input logic rt, input logic ev,
                        input logic [1:0] eid, input logic [3:0] erdy,
                        input logic [2:0] ecnt, input logic eovf);
        exp_t e;
        @(posedge clk);
        #1;
        reset         = rs;
        req_val       = rq;
        out_rdy       = rd;
        credit_return = rt;
        e.nm   = nm;
        e.v    = ev;
        e.id   = eid;
        e.rdy  = erdy;
        e.cnt  = ecnt;
        e.zero = (ecnt == 3'd0);
        e.ovf  = eovf;
        q.push_back(e);
    endtask

    // Monitor: outputs are combinational, so they are stable by the negedge.
    initial begin
        exp_t e;
        logic ok;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e  = q.pop_front();
                ok = (out_val == e.v) && (req_rdy == e.rdy) &&
                     (credit_count == e.cnt) && (credit_zero == e.zero) &&
                     (credit_overflow == e.ovf) && (!e.v || out_id == e.id);
                n_checks++;
                if (ok) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got val=%b id=%0d rdy=%b cnt=%0d zero=%b ovf=%b, want val=%b id=%0d rdy=%b cnt=%0d zero=%b ovf=%b",
                             e.nm, out_val, out_id, req_rdy, credit_count, credit_zero,
                             credit_overflow, e.v, e.id, e.rdy, e.cnt, e.zero, e.ovf);
                end
            end
        end
    end

    initial begin
        int waited;
        reset         = 1'b1;
        req_val       = 4'b1111;
        out_rdy       = 1'b1;
        credit_return = 1'b0;

        step("reset_hold", 1, 4'b1111, 1, 0, 0, 0, 4'b0000, 3'd4, 0);

        step("rr_g0", 0, 4'b1111, 1, 0, 1, 0, 4'b0001, 3'd4, 0);
        step("rr_g1", 0, 4'b1111, 1, 0, 1, 1, 4'b0010, 3'd3, 0);
        step("rr_g2", 0, 4'b1111, 1, 0, 1, 2, 4'b0100, 3'd2, 0);
        step("rr_g3", 0, 4'b1111, 1, 0, 1, 3, 4'b1000, 3'd1, 0);
        step("rr_zero", 0, 4'b1111, 1, 0, 0, 0, 4'b0000, 3'd0, 0);

`ifdef VC_CREDIT_ARB_BYPASS_EN
        step("ret_bypass", 0, 4'b0100, 1, 1, 1, 2, 4'b0100, 3'd0, 0);
        step("ret_after", 0, 4'b0100, 1, 0, 0, 0, 4'b0000, 3'd0, 0);
`else
        step("ret_blocked", 0, 4'b0100, 1, 1, 0, 0, 4'b0000, 3'd0, 0);
        step("ret_next", 0, 4'b0100, 1, 0, 1, 2, 4'b0100, 3'd1, 0);
`endif

        step("refill0", 0, 4'b0000, 1, 1, 0, 0, 4'b0000, 3'd0, 0);
        step("refill1", 0, 4'b0000, 1, 1, 0, 0, 4'b0000, 3'd1, 0);
        step("refill2", 0, 4'b0000, 1, 1, 0, 0, 4'b0000, 3'd2, 0);
        step("refill3", 0, 4'b0000, 1, 1, 0, 0, 4'b0000, 3'd3, 0);

        step("wrap_g3", 0, 4'b1001, 1, 0, 1, 3, 4'b1000, 3'd4, 0);
        step("wrap_g0", 0, 4'b1001, 1, 0, 1, 0, 4'b0001, 3'd3, 0);
        step("wrap_ptr1", 0, 4'b1111, 0, 0, 1, 1, 4'b0000, 3'd2, 0);

        step("stall0", 0, 4'b0010, 0, 0, 1, 1, 4'b0000, 3'd2, 0);
        step("stall1", 0, 4'b0010, 0, 0, 1, 1, 4'b0000, 3'd2, 0);
        step("stall2", 0, 4'b0010, 0, 0, 1, 1, 4'b0000, 3'd2, 0);
        step("stall_ptr", 0, 4'b1111, 0, 0, 1, 1, 4'b0000, 3'd2, 0);

        step("fire_ret", 0, 4'b0010, 1, 1, 1, 1, 4'b0010, 3'd2, 0);
        step("fire_ret_cnt", 0, 4'b0000, 1, 0, 0, 0, 4'b0000, 3'd2, 0);

        step("top_up2", 0, 4'b0000, 1, 1, 0, 0, 4'b0000, 3'd2, 0);
        step("top_up3", 0, 4'b0000, 1, 1, 0, 0, 4'b0000, 3'd3, 0);
        step("ovf_ret", 0, 4'b0000, 1, 1, 0, 0, 4'b0000, 3'd4, 0);
        step("ovf_set", 0, 4'b0000, 1, 0, 0, 0, 4'b0000, 3'd4, 1);
        step("ovf_sticky", 0, 4'b0001, 1, 0, 1, 0, 4'b0001, 3'd4, 1);

        step("pre_rst_g1", 0, 4'b1111, 1, 0, 1, 1, 4'b0010, 3'd3, 1);
        step("pre_rst_g2", 0, 4'b1111, 1, 0, 1, 2, 4'b0100, 3'd2, 1);
        step("async_rst", 1, 4'b1111, 1, 0, 0, 0, 4'b0000, 3'd4, 0);
        step("post_rst_g0", 0, 4'b1111, 1, 0, 1, 0, 4'b0001, 3'd4, 0);
        step("post_rst_g1", 0, 4'b1111, 1, 0, 1, 1, 4'b0010, 3'd3, 0);
        step("idle", 0, 4'b0000, 1, 0, 0, 0, 4'b0000, 3'd2, 0);

        waited = 0;
        while (q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending entries, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
